// File: rtl/fb_double_buffer_pkg.sv
// Shared framebuffer definitions: default geometry, pixel format, swap FSM encoding
// and the coordinate-to-address mapping.
package fb_double_buffer_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 400;
  localparam int unsigned FB_HEIGHT_DEF = 240;
  localparam int unsigned COLOR_W       = 16;
  localparam int unsigned TRANSP_BIT    = 0;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // Row-major linear address; the caller truncates to its bank address width.
  function automatic int unsigned xy_to_addr(int unsigned x, int unsigned y, int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/fb_double_buffer_if.sv
// GPU write stream, scanout read port and swap control of the double-buffered framebuffer.
interface fb_double_buffer_if #(
  parameter int unsigned FB_WIDTH  = 400,
  parameter int unsigned FB_HEIGHT = 240
);
  localparam int unsigned X_W = $clog2(FB_WIDTH) + 1;
  localparam int unsigned Y_W = $clog2(FB_HEIGHT) + 1;

  logic [X_W-1:0] fb_x;
  logic [Y_W-1:0] fb_y;
  logic [15:0]    fb_color;
  logic           fb_write;
  logic [X_W-1:0] disp_x;
  logic [Y_W-1:0] disp_y;
  logic           disp_read;
  logic           disp_vblank;
  logic [15:0]    disp_color;
  logic           disp_valid;
  logic           ctrl_swap;
  logic           swap_pending;
  logic           front_buffer;

  modport master (
    output fb_x, fb_y, fb_color, fb_write,
    output disp_x, disp_y, disp_read, disp_vblank, ctrl_swap,
    input  disp_color, disp_valid, swap_pending, front_buffer
  );

  modport slave (
    input  fb_x, fb_y, fb_color, fb_write,
    input  disp_x, disp_y, disp_read, disp_vblank, ctrl_swap,
    output disp_color, disp_valid, swap_pending, front_buffer
  );
endinterface

// File: rtl/fb_bank.sv
// One framebuffer bank: simple dual-port RAM with a synchronous write port and a
// registered read port.
module fb_bank #(
  parameter int unsigned DEPTH  = 96000,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: no reset on the array or its read register, so the tools can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fb_double_buffer.sv
// Double-buffered framebuffer: GPU writes the back bank, scanout reads the front bank
// through a 2-cycle pipeline, and requested swaps are deferred to vertical blanking.
module fb_double_buffer
  import fb_double_buffer_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
  input logic          clk,
  input logic          reset,
  fb_double_buffer_if.slave bus
);
  localparam int unsigned DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned X_W    = $clog2(FB_WIDTH) + 1;
  localparam int unsigned Y_W    = $clog2(FB_HEIGHT) + 1;

  logic              wr_ok, wr_bank0, wr_bank1;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_ok_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              rd_req_q, rd_bank_q, rd_ok_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              valid_q, sel_bank_q, sel_ok_q;
  logic [COLOR_W-1:0] rdata0, rdata1;
  swap_state_e       state_q, state_d;
  logic              front_q, front_d;
  logic              swap_prev_q, swap_rise;

  assign wr_ok = bus.fb_write && (bus.fb_x < X_W'(FB_WIDTH)) && (bus.fb_y < Y_W'(FB_HEIGHT));
  assign wr_addr = ADDR_W'(xy_to_addr(32'(bus.fb_x), 32'(bus.fb_y), FB_WIDTH));
  assign wr_bank0 = wr_ok && front_q;
  assign wr_bank1 = wr_ok && !front_q;

  // Out-of-range reads park on address 0 so the RAM is never indexed past its depth.
  assign rd_ok_d   = (bus.disp_x < X_W'(FB_WIDTH)) && (bus.disp_y < Y_W'(FB_HEIGHT));
  assign rd_addr_d = rd_ok_d ? ADDR_W'(xy_to_addr(32'(bus.disp_x), 32'(bus.disp_y), FB_WIDTH))
                             : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ok_q    <= 1'b0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
      sel_bank_q <= 1'b0;
      sel_ok_q   <= 1'b0;
    end else begin
      rd_req_q   <= bus.disp_read;
      rd_bank_q  <= front_q;
      rd_ok_q    <= rd_ok_d;
      rd_addr_q  <= rd_addr_d;
      valid_q    <= rd_req_q;
      sel_bank_q <= rd_bank_q;
      sel_ok_q   <= rd_ok_q;
    end
  end

  fb_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(COLOR_W)) u_bank0 (
    .clk(clk), .we_i(wr_bank0), .waddr_i(wr_addr), .wdata_i(bus.fb_color),
    .re_i(rd_req_q), .raddr_i(rd_addr_q), .rdata_o(rdata0)
  );

  fb_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(COLOR_W)) u_bank1 (
    .clk(clk), .we_i(wr_bank1), .waddr_i(wr_addr), .wdata_i(bus.fb_color),
    .re_i(rd_req_q), .raddr_i(rd_addr_q), .rdata_o(rdata1)
  );

  assign bus.disp_valid = valid_q;
  assign bus.disp_color = (valid_q && sel_ok_q) ? (sel_bank_q ? rdata1 : rdata0) : '0;

  assign swap_rise = bus.ctrl_swap && !swap_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SWAP_IDLE;
      front_q     <= 1'b0;
      swap_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      swap_prev_q <= bus.ctrl_swap;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    case (state_q)
      SWAP_IDLE:    if (swap_rise) state_d = SWAP_PENDING;
      SWAP_PENDING: if (bus.disp_vblank) begin
        state_d = SWAP_IDLE;
        front_d = !front_q;
      end
      default:      state_d = SWAP_IDLE;
    endcase
  end

  assign bus.swap_pending = (state_q == SWAP_PENDING);
  assign bus.front_buffer = front_q;
endmodule
